// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the dmem_arbiter slice.
//   DMEM_ADDR_W / DMEM_DATA_W : default word-address and data widths (32x32 RAM)
//   state_t                   : arbiter FSM encoding (IDLE, ISSUE, RESP)
//   RAM_READ / RAM_WRITE      : values of the RAM readWrite strobe
//   port_onehot()             : maps a requester id onto its one-hot pulse vector
// Optional feature macro used by this slice: DMEM_RR_ARB_EN (round-robin arbitration).
package dmem_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

  // One-hot pulse vector {port1, port0} for a requester id.
  function automatic logic [1:0] port_onehot(input logic id);
    logic [1:0] oh;
    if (id) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dmem_arb2.sv
// dmem_arb2: two-way request arbiter for dmem_arbiter.
//   req[1:0] in  : request vector {port1, port0}
//   req_any  out : at least one request is present
//   pick     out : winning port id (only meaningful while req_any)
//   clk, rst_n, update (present only with DMEM_RR_ARB_EN):
//                  pointer clock/reset and "a grant is being made" strobe
// With DMEM_RR_ARB_EN defined the winner of a tie is the port not granted last;
// the pointer resets to port 1 so port 0 wins the first tie. Without it, port 0
// always wins and no pointer state exists.
module dmem_arb2 (
  input  logic [1:0] req,
  output logic       req_any,
  output logic       pick
`ifdef DMEM_RR_ARB_EN
  ,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update
`endif
);

  assign req_any = req[0] | req[1];

`ifdef DMEM_RR_ARB_EN
  logic last_r;

  // Winner selection: a tie goes to the port that was not granted last.
  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = ~last_r;
    end else if (req[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
  end

  // Last-grant pointer, advanced whenever the arbiter hands out a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (update) begin
      last_r <= pick;
    end else begin
      last_r <= last_r;
    end
  end
`else
  // Winner selection: fixed priority, port 0 always first.
  always_comb begin
    pick = 1'b0;
    if (req[0]) begin
      pick = 1'b0;
    end else if (req[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data RAM between the core
// load/store unit (port 0) and the program/debug loader (port 1).
// Each access runs IDLE -> ISSUE (-> RESP for reads) -> IDLE.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   m0_*/m1_* req,we,addr,wdata requester inputs (req held until gnt)
//   m0_gnt/m1_gnt              1-cycle grant pulse (during ISSUE)
//   m0_rvalid/m1_rvalid        1-cycle read-data-valid pulse (during RESP)
//   m_rdata                    shared read data, qualified by rvalid
//   ram_dataIN/ram_address/ram_readWrite  RAM command (readWrite 1 = read)
//   ram_dataOUT                RAM registered read data
// Build option: define DMEM_RR_ARB_EN for round-robin arbitration; otherwise
// port 0 has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic [DATA_W-1:0] ram_dataIN,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_readWrite,
  input  logic [DATA_W-1:0] ram_dataOUT
);

  state_t            state_r;
  logic              id_r;
  logic              we_r;
  logic [1:0]        gnt_r;
  logic [1:0]        rvalid_r;
  logic [DATA_W-1:0] rdata_hold_r;

  logic              req_any_s;
  logic              pick_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

`ifdef DMEM_RR_ARB_EN
  logic              arb_update_s;
  assign arb_update_s = (state_r == IDLE) && req_any_s;
`endif

  dmem_arb2 u_arb (
    .req     ({m1_req, m0_req}),
    .req_any (req_any_s),
    .pick    (pick_s)
`ifdef DMEM_RR_ARB_EN
    ,
    .clk     (clk),
    .rst_n   (rst_n),
    .update  (arb_update_s)
`endif
  );

  // Route the winning requester's command towards the request latch.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (pick_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Access sequencer: latches the winner in IDLE, drives the RAM in ISSUE,
  // returns read data in RESP. ram_readWrite is only RAM_WRITE during the
  // ISSUE cycle of a write, so the RAM never sees a stray write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      id_r          <= 1'b0;
      we_r          <= 1'b0;
      gnt_r         <= 2'b00;
      rvalid_r      <= 2'b00;
      rdata_hold_r  <= '0;
      ram_readWrite <= RAM_READ;
      ram_address   <= '0;
      ram_dataIN    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_r         <= 2'b00;
          rvalid_r      <= 2'b00;
          ram_readWrite <= RAM_READ;
          if (req_any_s) begin
            state_r       <= ISSUE;
            id_r          <= pick_s;
            we_r          <= sel_we_s;
            ram_address   <= sel_addr_s;
            ram_dataIN    <= sel_wdata_s;
            ram_readWrite <= sel_we_s ? RAM_WRITE : RAM_READ;
            gnt_r         <= port_onehot(pick_s);
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          gnt_r         <= 2'b00;
          ram_readWrite <= RAM_READ;
          if (we_r) begin
            state_r  <= IDLE;
            rvalid_r <= 2'b00;
          end else begin
            state_r  <= RESP;
            rvalid_r <= port_onehot(id_r);
          end
        end
        RESP: begin
          gnt_r         <= 2'b00;
          rvalid_r      <= 2'b00;
          ram_readWrite <= RAM_READ;
          rdata_hold_r  <= ram_dataOUT;
          state_r       <= IDLE;
        end
        default: begin
          gnt_r         <= 2'b00;
          rvalid_r      <= 2'b00;
          ram_readWrite <= RAM_READ;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign m0_gnt    = gnt_r[0];
  assign m1_gnt    = gnt_r[1];
  assign m0_rvalid = rvalid_r[0];
  assign m1_rvalid = rvalid_r[1];

  // The RAM's own output register provides the RESP-cycle data, so read
  // data passes straight through while rvalid is high and is held from
  // a register afterwards; this keeps rvalid two cycles after the request.
  assign m_rdata = (state_r == RESP) ? ram_dataOUT : rdata_hold_r;

endmodule
